// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants shared by the VGA sync generator and its axis counters.
// The sync window of each axis begins after the active region plus front porch.
package vga_timing_pkg;

    localparam int CNT_W    = 10;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    function automatic int axisTotal(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int H_TOTAL      = axisTotal(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL      = axisTotal(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping position counter whose sync/active flags are registered
// from the next count, so the flags line up with the count on the same clk edge.
module vga_axis_counter #(
    parameter int ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int FP     = vga_timing_pkg::H_FP,
    parameter int SYNC   = vga_timing_pkg::H_SYNC,
    parameter int BP     = vga_timing_pkg::H_BP,
    parameter bit POL    = 1'b0,
    parameter int CNT_W  = vga_timing_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             sync,
    output logic             active
);
    import vga_timing_pkg::*;

    localparam int               TOTAL      = axisTotal(ACTIVE, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + SYNC);
    localparam logic [CNT_W-1:0] ACT_END    = CNT_W'(ACTIVE);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic             r_sync;
    logic             r_active;

    // Wrap compare comes before the increment so the counter never overflows its width.
    always_comb begin
        w_cntNext = r_cnt;
        if (en) begin
            w_cntNext = (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_sync   <= ~POL;
            r_active <= 1'b1;
        end else begin
            r_cnt    <= w_cntNext;
            r_sync   <= (w_cntNext >= SYNC_START && w_cntNext < SYNC_END) ? POL : ~POL;
            r_active <= (w_cntNext < ACT_END);
        end
    end

    assign cnt    = r_cnt;
    assign wrap   = en && (r_cnt == LAST);
    assign sync   = r_sync;
    assign active = r_active;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: turns rising edges of the divided pixel clock into pixel ticks and
// drives hsync/vsync, active video, pixel coordinates and line/frame start pulses.
module vga_sync_gen #(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = vga_timing_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vga_clk,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start
);
    import vga_timing_pkg::*;

    logic             r_vgaClkD;
    logic             r_lineStart;
    logic             r_frameStart;
    logic             w_tick;
    logic             w_vEn;
    logic             w_hWrap;
    logic             w_vWrap;
    logic             w_hSync;
    logic             w_vSync;
    logic             w_hActive;
    logic             w_vActive;
    logic [CNT_W-1:0] w_hCnt;
    logic [CNT_W-1:0] w_vCnt;

    assign w_tick = vga_clk & ~r_vgaClkD;
    assign w_vEn  = w_tick & w_hWrap;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .CNT_W(CNT_W)
    ) u_hAxis (
        .clk(clk), .rst(rst), .en(w_tick),
        .cnt(w_hCnt), .wrap(w_hWrap), .sync(w_hSync), .active(w_hActive)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .CNT_W(CNT_W)
    ) u_vAxis (
        .clk(clk), .rst(rst), .en(w_vEn),
        .cnt(w_vCnt), .wrap(w_vWrap), .sync(w_vSync), .active(w_vActive)
    );

    // Edge-detector history is held low in reset, so the first high sample afterwards is a tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vgaClkD    <= 1'b0;
            r_lineStart  <= 1'b0;
            r_frameStart <= 1'b0;
        end else begin
            r_vgaClkD    <= vga_clk;
            r_lineStart  <= w_hWrap;
            r_frameStart <= w_vWrap;
        end
    end

    assign hsync       = w_hSync;
    assign vsync       = w_vSync;
    assign active      = w_hActive & w_vActive;
    assign x           = active ? w_hCnt : '0;
    assign y           = active ? w_vCnt : '0;
    assign line_start  = r_lineStart;
    assign frame_start = r_frameStart;

endmodule
